// File: rtl/servo_pwm_decoder_pkg.sv
// servo_pkg: shared types and constants for the servo PWM decoder.
//   servo_state_e  per-channel frame FSM state
//   *_US constants frame validity window and timeout, in microseconds
//   high_to_pos()  maps a measured high time to an 8-bit position
package servo_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } servo_state_e;

  // High-time quantities are 12 bits wide so the 2500 us upper bound is
  // representable; the counter itself saturates at 2047.
  localparam logic [11:0] MIN_HIGH_US   = 12'd500;
  localparam logic [11:0] MAX_HIGH_US   = 12'd2500;
  localparam logic [11:0] POS_BASE_US   = 12'd1000;
  localparam logic [11:0] HIGH_SAT_US   = 12'd2047;

  localparam logic [15:0] MIN_PERIOD_US = 16'd15000;
  localparam logic [15:0] MAX_PERIOD_US = 16'd25000;
  localparam logic [15:0] TIMEOUT_US    = 16'd25001;
  localparam logic [15:0] PERIOD_SAT_US = 16'd32767;

  // 0 below 1000 us, then 4 us per step, clamped at 255.
  function automatic logic [7:0] high_to_pos(input logic [11:0] high_us);
    logic [11:0] steps;
    logic [7:0]  result;
    steps  = '0;
    result = '0;
    if (high_us >= POS_BASE_US) begin
      steps = (high_us - POS_BASE_US) >> 2;
      if (steps > 12'd255) begin
        result = '1;
      end else begin
        result = steps[7:0];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/servo_pwm_decoder_channel.sv
// servo_pwm_channel: decodes one asynchronous servo PWM input.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   tick   one-cycle 1 us strobe from the shared prescaler
//   pwm    raw asynchronous PWM input
//   pos    last valid decoded position (held across invalid frames)
//   upd    one-cycle strobe when pos is written
//   locked last closed frame was valid and no timeout since
module servo_pwm_channel
  import servo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       pwm,
  output logic [7:0] pos,
  output logic       upd,
  output logic       locked
);

  logic sync1, sync2, pwm_d;
  logic rise_q, fall_q;

  servo_state_e state, state_n;
  logic [11:0]  high_us, high_n, high_inc;
  logic [15:0]  period_us, period_n, period_inc;
  logic [7:0]   pos_n;
  logic         upd_n, locked_n;
  logic         timeout, frame_ok;

  // Two-flop synchronizer, then a delayed copy for edge detection. The edge
  // pulses are registered so a pwm edge reaches the FSM after a fixed three
  // cycles, giving upd a constant four-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      pwm_d  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync1  <= pwm;
      sync2  <= sync1;
      pwm_d  <= sync2;
      rise_q <= sync2 & ~pwm_d;
      fall_q <= ~sync2 & pwm_d;
    end
  end

  // Saturating increments, plus the frame checks. The period check uses the
  // value including the current tick so the measured period equals the
  // rising-edge spacing in microseconds.
  always_comb begin
    high_inc = high_us;
    if (tick && (high_us != HIGH_SAT_US)) begin
      high_inc = high_us + 12'd1;
    end
    period_inc = period_us;
    if (tick && (period_us != PERIOD_SAT_US)) begin
      period_inc = period_us + 16'd1;
    end
    timeout  = (period_inc >= TIMEOUT_US);
    frame_ok = (high_us >= MIN_HIGH_US) && (high_us <= MAX_HIGH_US) &&
               (period_inc >= MIN_PERIOD_US) && (period_inc <= MAX_PERIOD_US);
  end

  always_comb begin
    state_n  = state;
    high_n   = high_us;
    period_n = period_us;
    pos_n    = pos;
    upd_n    = 1'b0;
    locked_n = locked;
    case (state)
      WAIT_RISE: begin
        if (rise_q) begin
          state_n  = HIGH;
          high_n   = '0;
          period_n = '0;
        end
      end
      HIGH: begin
        high_n   = high_inc;
        period_n = period_inc;
        if (timeout) begin
          state_n  = WAIT_RISE;
          locked_n = 1'b0;
        end else if (fall_q) begin
          state_n = LOW;
        end
      end
      LOW: begin
        period_n = period_inc;
        // A timeout swallows a coincident rising edge.
        if (timeout) begin
          state_n  = WAIT_RISE;
          locked_n = 1'b0;
        end else if (rise_q) begin
          if (frame_ok) begin
            pos_n    = high_to_pos(high_us);
            upd_n    = 1'b1;
            locked_n = 1'b1;
          end else begin
            locked_n = 1'b0;
          end
          state_n  = HIGH;
          high_n   = '0;
          period_n = '0;
        end
      end
      default: state_n = WAIT_RISE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_RISE;
      high_us   <= '0;
      period_us <= '0;
      pos       <= '0;
      upd       <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_n;
      high_us   <= high_n;
      period_us <= period_n;
      pos       <= pos_n;
      upd       <= upd_n;
      locked    <= locked_n;
    end
  end

endmodule

// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: NUM_CH independent servo PWM decoders sharing a 1 us tick.
//   CLOCK_50  system clock (CLK_HZ)
//   KEY0      asynchronous active-low reset
//   pwm_in    asynchronous servo inputs, bit i = channel i
//   pos       decoded positions, channel i at [8i+7:8i]
//   upd       one-cycle strobe per channel when its pos is written
//   locked    per-channel valid-frame indication
module servo_pwm_decoder #(
  parameter int CLK_HZ = 50_000_000,
  parameter int NUM_CH = 5
) (
  input  logic                  CLOCK_50,
  input  logic                  KEY0,
  input  logic [NUM_CH-1:0]     pwm_in,
  output logic [8*NUM_CH-1:0]   pos,
  output logic [NUM_CH-1:0]     upd,
  output logic [NUM_CH-1:0]     locked
);

  // A 1 MHz clock degenerates to a tick on every cycle.
  localparam int TICK_DIV = (CLK_HZ / 1_000_000 > 1) ? (CLK_HZ / 1_000_000) : 1;
  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc;
  logic               tick;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_pwm_channel u_ch (
      .clk    (CLOCK_50),
      .rst_n  (KEY0),
      .tick   (tick),
      .pwm    (pwm_in[i]),
      .pos    (pos[8*i +: 8]),
      .upd    (upd[i]),
      .locked (locked[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Testbench for servo_pwm_decoder. Runs at CLK_HZ = 1 MHz so one cycle is
// one microsecond. Each channel's waveform is a list of (rise, fall) cycle
// pairs; a reference model derives the expected upd/pos/locked events from
// those lists and queues them per channel, and a monitor checks the DUT
// outputs against the accumulated expectation on every cycle.
module tb_servo_pwm_decoder;

  localparam int NUM_CH = 5;
  localparam int CLK_HZ = 1_000_000;
  localparam int TO     = 25001;
  localparam int LAT    = 3;   // rise sampled at cycle n -> upd visible after edge n+3

  logic                 CLOCK_50 = 1'b0;
  logic                 KEY0     = 1'b0;
  logic [NUM_CH-1:0]    pwm_in   = '0;
  logic [8*NUM_CH-1:0]  pos;
  logic [NUM_CH-1:0]    upd;
  logic [NUM_CH-1:0]    locked;

  servo_pwm_decoder #(.CLK_HZ(CLK_HZ), .NUM_CH(NUM_CH)) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY0),
    .pwm_in   (pwm_in),
    .pos      (pos),
    .upd      (upd),
    .locked   (locked)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {int ch; int ep; int r; int f;} seg_t;
  typedef struct {int cyc; bit upd; bit [7:0] pos; bit lk;} ev_t;

  seg_t seg_q[$];
  ev_t  evq[NUM_CH][$];

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;
  bit drv_en      = 1'b0;

  function automatic bit [7:0] ref_pos(input int h);
    int q;
    if (h > 2047) h = 2047;
    if (h < 1000) return 8'd0;
    q = (h - 1000) / 4;
    if (q > 255) return 8'd255;
    return q[7:0];
  endfunction

  function automatic bit ref_valid(input int h, input int p);
    if (h > 2047) h = 2047;
    return (h >= 500) && (h <= 2500) && (p >= 15000) && (p <= 25000);
  endfunction

  function automatic bit level(input int ch, input int n);
    foreach (seg_q[i]) begin
      if (seg_q[i].ch == ch && n >= seg_q[i].r && n < seg_q[i].f) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic add_seg(input int ch, input int ep, input int r, input int w);
    seg_t s;
    s = '{ch, ep, r, r + w};
    seg_q.push_back(s);
  endtask

  task automatic push_ev(input int ch, input int c, input bit u, input bit [7:0] p,
                         input bit l, input int lim);
    ev_t e;
    e = '{c, u, p, l};
    if (c < lim) evq[ch].push_back(e);
  endtask

  // Frame semantics: frame opens at a rise, closes at the next rise. Its
  // period is the rise spacing, its high time is fall - rise. A frame still
  // open TO cycles after its rise times out; a rise exactly then is ignored.
  task automatic model_epoch(input int ch, input int ep, input int lim);
    bit       open = 1'b0;
    int       s = 0, fl = 0, d = 0, r = 0;
    bit [7:0] p = 8'd0;
    foreach (seg_q[i]) begin
      if (seg_q[i].ch != ch || seg_q[i].ep != ep) continue;
      r = seg_q[i].r;
      if (open) begin
        d = r - s;
        if (d >= TO) begin
          push_ev(ch, s + LAT + TO, 1'b0, p, 1'b0, lim);
          open = 1'b0;
          if (d == TO) continue;
        end else if (ref_valid(fl - s, d)) begin
          p = ref_pos(fl - s);
          push_ev(ch, r + LAT, 1'b1, p, 1'b1, lim);
        end else begin
          push_ev(ch, r + LAT, 1'b0, p, 1'b0, lim);
        end
      end
      open = 1'b1;
      s    = r;
      fl   = seg_q[i].f;
    end
    if (open) push_ev(ch, s + LAT + TO, 1'b0, p, 1'b0, lim);
  endtask

  // Driver: level for the edge about to come is set on the falling edge.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (drv_en) begin
        for (int c = 0; c < NUM_CH; c++) pwm_in[c] = level(c, cyc + 1);
      end
    end
  end

  // Monitor: applies matured expectations and compares all outputs.
  initial begin
    bit [NUM_CH-1:0]   eu;
    bit [NUM_CH-1:0]   el;
    bit [8*NUM_CH-1:0] ep;
    ev_t               e;
    el = '0;
    ep = '0;
    forever begin
      @(negedge CLOCK_50);
      #1;
      if (mon_en && KEY0) begin
        eu = '0;
        for (int c = 0; c < NUM_CH; c++) begin
          while (evq[c].size() > 0 && evq[c][0].cyc <= cyc) begin
            e = evq[c].pop_front();
            if (e.upd && e.cyc == cyc) eu[c] = 1'b1;
            ep[8*c +: 8] = e.pos;
            el[c]        = e.lk;
          end
        end
        vectors++;
        if (upd !== eu || pos !== ep || locked !== el) begin
          miscompares++;
          if (miscompares <= 20)
            $display("FAIL outputs cycle %0d: upd=%b exp %b pos=%h exp %h locked=%b exp %b",
                     cyc, upd, eu, pos, ep, locked, el);
        end
      end
    end
  end

  initial begin
    int t0, t1, t2, t3, p0, p2, rst_at, rel_at, e0, e1, end_at, h2;

    t0     = 100;
    p0     = 15000 + $urandom_range(0, 400);
    t1     = t0 + p0;
    t2     = t1 + 15000;                      // exact minimum period
    p2     = 15000 + $urandom_range(0, 400);
    t3     = t2 + p2;
    rst_at = t3 + 700;                        // ch0 is mid-high here
    rel_at = t3 + 2600;                       // every input is low by now
    e0     = rel_at + 50;
    e1     = e0 + 15000 + $urandom_range(0, 500);
    end_at = e1 + 200;

    // ch0: 1500 us pulses, locks at 125
    add_seg(0, 0, t0, 1500); add_seg(0, 0, t1, 1500);
    add_seg(0, 0, t2, 1500); add_seg(0, 0, t3, 1500);
    // ch1: 900 us -> 0, 2200 us -> 255, 2500 us boundary -> 255
    add_seg(1, 0, t0, 900);  add_seg(1, 0, t1, 2200);
    add_seg(1, 0, t2, 2500); add_seg(1, 0, t3, $urandom_range(500, 999));
    // ch2: locks, then held low until it times out
    add_seg(2, 0, t0, $urandom_range(1000, 2000));
    add_seg(2, 0, t1, $urandom_range(1000, 2000));
    // ch3: valid, then 3000 us / 10000 us period, short period, 499 us high
    add_seg(3, 0, t0, $urandom_range(1000, 2000));
    add_seg(3, 0, t1, 3000);
    add_seg(3, 0, t1 + 10000, 1500);
    add_seg(3, 0, t2, 499);
    add_seg(3, 0, t3, $urandom_range(1000, 2000));
    // ch4: 500 us boundary, then a rise exactly at the timeout
    add_seg(4, 0, t0, 500);
    add_seg(4, 0, t1, $urandom_range(1000, 2047));
    add_seg(4, 0, t1 + TO, 1000);
    add_seg(4, 0, t3, $urandom_range(500, 2047));
    // after reset: identical aligned frames on every channel
    h2 = $urandom_range(1000, 2047);
    for (int c = 0; c < NUM_CH; c++) begin
      add_seg(c, 1, e0, h2);
      add_seg(c, 1, e1, h2);
    end

    for (int c = 0; c < NUM_CH; c++) begin
      model_epoch(c, 0, rst_at);
      push_ev(c, rst_at, 1'b0, 8'd0, 1'b0, end_at);
      model_epoch(c, 1, end_at);
    end

    drv_en = 1'b1;
    #22;
    KEY0   = 1'b1;
    mon_en = 1'b1;

    while (cyc < rst_at) begin
      @(posedge CLOCK_50);
      #2;
    end
    KEY0 = 1'b0;
    #1;
    vectors++;
    if (pos !== '0) begin
      miscompares++;
      $display("FAIL reset_pos: pos=%h exp 0", pos);
    end
    vectors++;
    if (upd !== '0) begin
      miscompares++;
      $display("FAIL reset_upd: upd=%b exp 0", upd);
    end
    vectors++;
    if (locked !== '0) begin
      miscompares++;
      $display("FAIL reset_locked: locked=%b exp 0", locked);
    end

    while (cyc < rel_at) begin
      @(posedge CLOCK_50);
      #2;
    end
    KEY0 = 1'b1;

    while (cyc < end_at) begin
      @(posedge CLOCK_50);
      #2;
    end
    mon_en = 1'b0;

    for (int c = 0; c < NUM_CH; c++) begin
      vectors++;
      if (evq[c].size() != 0) begin
        miscompares++;
        $display("FAIL pending_events ch%0d: %0d left exp 0", c, evq[c].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
